// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: control-side sequencer for the multicycle divider and multiplier.
// It launches DIV/MULT operations with a one-cycle start pulse, waits for the
// unit's done level, and writes the result into the architectural HI/LO
// registers. It also serves MTHI/MTLO moves directly from IDLE. While an
// operation is in flight the pipeline is stalled. Divide-by-zero and
// handshake timeouts raise sticky flags that only reset clears.
module muldiv_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CW      = 7
) (
    input  logic        Clock,
    input  logic        reset,
    input  logic        OpValid,
    input  logic [2:0]  Op,
    input  logic [31:0] OpA,
    input  logic [31:0] OpB,
    output logic [31:0] ArgA,
    output logic [31:0] ArgB,
    output logic        CtoD,
    output logic        CtoM,
    input  logic        DtoC,
    input  logic        MtoC,
    input  logic        DivZero,
    input  logic [31:0] DivHigh,
    input  logic [31:0] DivLow,
    input  logic [31:0] MulHigh,
    input  logic [31:0] MulLow,
    output logic        Stall,
    output logic [31:0] HiOut,
    output logic [31:0] LoOut,
    output logic        DivZeroExc,
    output logic        Timeout
);

    // Request codes
    localparam logic [2:0] OP_DIV  = 3'b001;
    localparam logic [2:0] OP_MULT = 3'b010;
    localparam logic [2:0] OP_MTHI = 3'b011;
    localparam logic [2:0] OP_MTLO = 3'b100;

    // Last counter value before the wait is abandoned. The counter is cleared
    // in the START state and is 0 on the first WAIT cycle, so reaching this
    // value means TIMEOUT cycles have been spent waiting.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DSTART = 3'd1,
        ST_DWAIT  = 3'd2,
        ST_MSTART = 3'd3,
        ST_MWAIT  = 3'd4
    } state_t;

    state_t        state_r;
    state_t        state_s;

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic          cnt_hit_s;

    logic [31:0]   arg_a_r, arg_a_s;
    logic [31:0]   arg_b_r, arg_b_s;
    logic [31:0]   hi_r, hi_s;
    logic [31:0]   lo_r, lo_s;
    logic          ctod_r, ctod_s;
    logic          ctom_r, ctom_s;
    logic          stall_r, stall_s;
    logic          dz_exc_r, dz_exc_s;
    logic          timeout_r, timeout_s;

    assign cnt_hit_s = (cnt_r == CNT_LAST);

    // State register: reset returns to IDLE and abandons any in-flight op
    always_ff @(posedge Clock) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: requests are only accepted in IDLE; a wait ends on done or timeout
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (OpValid && (Op == OP_DIV)) begin
                    state_s = ST_DSTART;
                end else if (OpValid && (Op == OP_MULT)) begin
                    state_s = ST_MSTART;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DSTART: begin
                state_s = ST_DWAIT;
            end
            ST_DWAIT: begin
                if (DtoC || cnt_hit_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DWAIT;
                end
            end
            ST_MSTART: begin
                state_s = ST_MWAIT;
            end
            ST_MWAIT: begin
                if (MtoC || cnt_hit_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_MWAIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output logic: next values of every registered output and of the wait counter
    always_comb begin
        arg_a_s   = arg_a_r;
        arg_b_s   = arg_b_r;
        hi_s      = hi_r;
        lo_s      = lo_r;
        dz_exc_s  = dz_exc_r;
        timeout_s = timeout_r;
        cnt_s     = cnt_r;
        // Start pulses and stall are Moore decodes of the upcoming state, so the
        // start pulse lasts exactly the one START cycle and stall falls in the
        // same cycle HI/LO take the result.
        ctod_s    = (state_s == ST_DSTART);
        ctom_s    = (state_s == ST_MSTART);
        stall_s   = (state_s != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                if (OpValid) begin
                    case (Op)
                        OP_DIV, OP_MULT: begin
                            arg_a_s = OpA;
                            arg_b_s = OpB;
                        end
                        OP_MTHI: begin
                            hi_s = OpA;
                        end
                        OP_MTLO: begin
                            lo_s = OpA;
                        end
                        default: begin
                            hi_s = hi_r;
                        end
                    endcase
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_DSTART, ST_MSTART: begin
                cnt_s = {CW{1'b0}};
            end
            ST_DWAIT: begin
                // Done takes priority over a timeout landing on the same edge
                if (DtoC) begin
                    if (DivZero) begin
                        dz_exc_s = 1'b1;
                    end else begin
                        hi_s = DivHigh;
                        lo_s = DivLow;
                    end
                end else if (cnt_hit_s) begin
                    timeout_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_MWAIT: begin
                // The divider's zero flag has no meaning for a multiply
                if (MtoC) begin
                    hi_s = MulHigh;
                    lo_s = MulLow;
                end else if (cnt_hit_s) begin
                    timeout_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                cnt_s = {CW{1'b0}};
            end
        endcase
    end

    // Output registers: reset clears all architectural state and sticky flags
    always_ff @(posedge Clock) begin
        if (!reset) begin
            arg_a_r   <= 32'd0;
            arg_b_r   <= 32'd0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            ctod_r    <= 1'b0;
            ctom_r    <= 1'b0;
            stall_r   <= 1'b0;
            dz_exc_r  <= 1'b0;
            timeout_r <= 1'b0;
            cnt_r     <= {CW{1'b0}};
        end else begin
            arg_a_r   <= arg_a_s;
            arg_b_r   <= arg_b_s;
            hi_r      <= hi_s;
            lo_r      <= lo_s;
            ctod_r    <= ctod_s;
            ctom_r    <= ctom_s;
            stall_r   <= stall_s;
            dz_exc_r  <= dz_exc_s;
            timeout_r <= timeout_s;
            cnt_r     <= cnt_s;
        end
    end

    assign ArgA       = arg_a_r;
    assign ArgB       = arg_b_r;
    assign CtoD       = ctod_r;
    assign CtoM       = ctom_r;
    assign Stall      = stall_r;
    assign HiOut      = hi_r;
    assign LoOut      = lo_r;
    assign DivZeroExc = dz_exc_r;
    assign Timeout    = timeout_r;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: table of operations applied to muldiv_ctrl with the bench
// acting as divider/multiplier; expected HI/LO/flags come from a reference
// model, are queued at request time and compared when the operation retires.
// Hand-written sequences cover reset, requests during a stall and reset
// mid-operation.
module tb_muldiv_ctrl;

    localparam int TIMEOUT = 64;
    localparam logic [2:0] OP_DIV  = 3'b001;
    localparam logic [2:0] OP_MULT = 3'b010;
    localparam logic [2:0] OP_MTHI = 3'b011;
    localparam logic [2:0] OP_MTLO = 3'b100;

    logic        Clock = 1'b0;
    logic        reset = 1'b0;
    logic        OpValid = 1'b0;
    logic [2:0]  Op = 3'd0;
    logic [31:0] OpA = 32'd0, OpB = 32'd0;
    logic [31:0] ArgA, ArgB;
    logic        CtoD, CtoM;
    logic        DtoC = 1'b0, MtoC = 1'b0, DivZero = 1'b0;
    logic [31:0] DivHigh = 32'd0, DivLow = 32'd0, MulHigh = 32'd0, MulLow = 32'd0;
    logic        Stall;
    logic [31:0] HiOut, LoOut;
    logic        DivZeroExc, Timeout;

    always #5 Clock = ~Clock;

    muldiv_ctrl #(.TIMEOUT(TIMEOUT), .CW(7)) dut (
        .Clock(Clock), .reset(reset), .OpValid(OpValid), .Op(Op),
        .OpA(OpA), .OpB(OpB), .ArgA(ArgA), .ArgB(ArgB),
        .CtoD(CtoD), .CtoM(CtoM), .DtoC(DtoC), .MtoC(MtoC),
        .DivZero(DivZero), .DivHigh(DivHigh), .DivLow(DivLow),
        .MulHigh(MulHigh), .MulLow(MulLow), .Stall(Stall),
        .HiOut(HiOut), .LoOut(LoOut), .DivZeroExc(DivZeroExc), .Timeout(Timeout)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          n;      // cycles of done latency after the start pulse
        bit          hang;   // unit never answers
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        logic        to;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];

    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
    logic        m_dz = 1'b0, m_to = 1'b0;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [63:0] prod;
        logic [31:0] rhi, rlo;
        logic        rdz;
        bit          is_long;
        int          cnt;
        exp_t        e;
        is_long = (v.op == OP_DIV) || (v.op == OP_MULT);
        prod = 64'd0;
        rhi  = 32'd0;
        rlo  = 32'd0;
        rdz  = 1'b0;
        // Reference unit behaviour and architectural model update
        if (v.op == OP_DIV) begin
            rdz = (v.b == 32'd0);
            if (rdz) begin
                rhi = 32'hBAD0BAD0;
                rlo = 32'h0BAD0BAD;
            end else begin
                rhi = v.a % v.b;
                rlo = v.a / v.b;
            end
        end else if (v.op == OP_MULT) begin
            prod = {32'd0, v.a} * {32'd0, v.b};
            rhi  = prod[63:32];
            rlo  = prod[31:0];
            rdz  = 1'b1;   // must be ignored on a multiply
        end
        if (is_long && v.hang) begin
            m_to = 1'b1;
        end else if (v.op == OP_DIV && rdz) begin
            m_dz = 1'b1;
        end else if (is_long) begin
            m_hi = rhi;
            m_lo = rlo;
        end else if (v.op == OP_MTHI) begin
            m_hi = v.a;
        end else if (v.op == OP_MTLO) begin
            m_lo = v.a;
        end
        e = '{hi: m_hi, lo: m_lo, dz: m_dz, to: m_to};
        sb.push_back(e);

        @(negedge Clock);
        OpValid = 1'b1; Op = v.op; OpA = v.a; OpB = v.b;
        @(negedge Clock);
        OpValid = 1'b0; Op = 3'd0; OpA = 32'd0; OpB = 32'd0;
        if (is_long) begin
            check("start_stall", idx, {31'd0, Stall}, 32'd1);
            check("ctod", idx, {31'd0, CtoD}, {31'd0, v.op == OP_DIV});
            check("ctom", idx, {31'd0, CtoM}, {31'd0, v.op == OP_MULT});
            check("arga", idx, ArgA, v.a);
            check("argb", idx, ArgB, v.b);
            @(negedge Clock);
            check("pulse_end", idx, {30'd0, CtoD, CtoM}, 32'd0);
            cnt = 0;
            while (Stall === 1'b1 && cnt < 300) begin
                if (!v.hang && cnt == v.n) begin
                    if (v.op == OP_DIV) begin
                        DtoC = 1'b1; DivZero = rdz; DivHigh = rhi; DivLow = rlo;
                    end else begin
                        MtoC = 1'b1; DivZero = rdz; MulHigh = rhi; MulLow = rlo;
                    end
                end
                cnt++;
                @(negedge Clock);
            end
            DtoC = 1'b0; MtoC = 1'b0; DivZero = 1'b0;
            check("stall_cycles", idx, cnt, v.hang ? TIMEOUT : v.n + 1);
        end else begin
            check("no_stall", idx, {31'd0, Stall}, 32'd0);
        end
        if (sb.size() == 0) begin
            check("sb_empty", idx, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("hi", idx, HiOut, e.hi);
            check("lo", idx, LoOut, e.lo);
            check("divzero", idx, {31'd0, DivZeroExc}, {31'd0, e.dz});
            check("timeout", idx, {31'd0, Timeout}, {31'd0, e.to});
        end
    endtask

    initial begin
        vecs[0]  = '{OP_DIV,  32'd100,        32'd7,    33, 1'b0};
        vecs[1]  = '{OP_DIV,  32'd5,          32'd0,    3,  1'b0};
        vecs[2]  = '{OP_MULT, 32'hFFFFFFFF,   32'd2,    4,  1'b0};
        vecs[3]  = '{OP_MTHI, 32'hCAFE0001,   32'd0,    0,  1'b0};
        vecs[4]  = '{OP_MTLO, 32'hBEEF0002,   32'd0,    0,  1'b0};
        vecs[5]  = '{3'b111,  32'h00000055,   32'd1,    0,  1'b0};
        vecs[6]  = '{OP_MULT, 32'd12345,      32'd6789, 0,  1'b0};
        vecs[7]  = '{OP_DIV,  32'hFFFFFFFF,   32'd16,   1,  1'b0};
        vecs[8]  = '{OP_DIV,  32'd1000,       32'd3,    TIMEOUT - 1, 1'b0};
        vecs[9]  = '{OP_MULT, 32'd7,          32'd9,    0,  1'b1};
        vecs[10] = '{OP_DIV,  32'd9,          32'd3,    2,  1'b0};
        vecs[11] = '{3'b000,  32'h12345678,   32'd2,    0,  1'b0};

        // Reset held with a pending MTHI request
        reset = 1'b0; OpValid = 1'b1; Op = OP_MTHI; OpA = 32'h11111111;
        repeat (2) @(negedge Clock);
        check("rst_hi", 0, HiOut, 32'd0);
        check("rst_lo", 0, LoOut, 32'd0);
        check("rst_stall", 0, {31'd0, Stall}, 32'd0);
        check("rst_flags", 0, {28'd0, DivZeroExc, Timeout, CtoD, CtoM}, 32'd0);
        check("rst_arga", 0, ArgA, 32'd0);
        OpValid = 1'b0; Op = 3'd0; OpA = 32'd0;
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], i);
        end

        // MTLO issued while a divide is waiting must be ignored
        @(negedge Clock);
        OpValid = 1'b1; Op = OP_DIV; OpA = 32'd50; OpB = 32'd5;
        @(negedge Clock);
        OpValid = 1'b0;
        @(negedge Clock);
        OpValid = 1'b1; Op = OP_MTLO; OpA = 32'h0000DEAD;
        @(negedge Clock);
        OpValid = 1'b0; Op = 3'd0; OpA = 32'd0;
        check("mtlo_ignored", 0, LoOut, m_lo);
        check("mtlo_stall", 0, {31'd0, Stall}, 32'd1);
        check("mtlo_arga", 0, ArgA, 32'd50);
        DtoC = 1'b1; DivHigh = 32'd0; DivLow = 32'd10;
        @(negedge Clock);
        DtoC = 1'b0;
        m_hi = 32'd0; m_lo = 32'd10;
        check("div2_stall", 0, {31'd0, Stall}, 32'd0);
        check("div2_lo", 0, LoOut, m_lo);
        check("div2_hi", 0, HiOut, m_hi);
        OpValid = 1'b1; Op = OP_MTHI; OpA = 32'h00001234;
        @(negedge Clock);
        OpValid = 1'b0; Op = 3'd0; OpA = 32'd0;
        check("mthi_after", 0, HiOut, 32'h00001234);

        // Reset mid-operation, then a late done
        @(negedge Clock);
        OpValid = 1'b1; Op = OP_MULT; OpA = 32'd3; OpB = 32'd4;
        @(negedge Clock);
        OpValid = 1'b0;
        repeat (3) @(negedge Clock);
        check("midop_stall", 0, {31'd0, Stall}, 32'd1);
        reset = 1'b0;
        @(negedge Clock);
        reset = 1'b1;
        check("midrst_stall", 0, {31'd0, Stall}, 32'd0);
        check("midrst_hi", 0, HiOut, 32'd0);
        check("midrst_lo", 0, LoOut, 32'd0);
        check("midrst_flags", 0, {30'd0, DivZeroExc, Timeout}, 32'd0);
        MtoC = 1'b1; MulHigh = 32'd0; MulLow = 32'd12;
        repeat (2) @(negedge Clock);
        MtoC = 1'b0;
        check("late_lo", 0, LoOut, 32'd0);
        check("late_stall", 0, {31'd0, Stall}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
